arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 4, data width per channel (legal 1..32).
REQ-003 SHALL have parameter MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL define SW = max(1, ceil(log2 N)) as the select width.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  reset, synchronous and active-high.
REQ-007 I  input  N*W  channel data, channel k in bits [k*W +: W].
REQ-008 I_valid  input  N  per-channel valid.
REQ-009 I_ready  output  N  per-channel ready, combinational.
REQ-010 O  output  W  registered output data.
REQ-011 O_valid  output  1  registered output valid.
REQ-012 O_ready  input  1  downstream ready.
REQ-013 O_sel  output  SW  registered index of the channel that supplied O.

Function
REQ-014 SHALL hold a single-entry output register {O, O_sel, O_valid}; a transfer occurs on a channel or on the output when its valid and ready are both high at a rising edge.
REQ-015 SHALL compute can_load = !O_valid | O_ready, combinationally.
REQ-016 SHALL compute a one-hot grant over I_valid each cycle: MODE 0 picks the first valid channel at or after pointer P, searching upward mod N; MODE 1 picks the lowest-index valid channel.
REQ-017 SHALL drive I_ready[k] = can_load & grant[k] & !RESET; at most one I_ready bit is high in any cycle.
REQ-018 SHALL, on a channel transfer from channel g, load O <= I[g], O_sel <= g and O_valid <= 1 at that edge, giving one cycle of latency from input to output.
REQ-019 SHALL clear O_valid when can_load is high and no I_valid bit is set; O and O_sel retain their previous values in this case.
REQ-020 SHALL hold O, O_sel and O_valid stable while O_valid=1 and O_ready=0 (backpressure), with all I_ready bits low.
REQ-021 SHALL sustain one transfer per cycle when O_ready is held high and any input is valid, including a simultaneous output drain and reload in the same cycle.
REQ-022 SHALL, in MODE 0, update P <= (g+1) mod N only on a channel transfer, and leave P unchanged otherwise; P wraps from N-1 to 0.
REQ-023 SHALL, in MODE 1, hold P constant at 0 and not use it.
REQ-024 SHALL ignore I_valid from a channel that is not granted in the current cycle; that channel's data is not consumed.
REQ-025 SHALL treat the output stage as a state machine with two states: EMPTY (O_valid=0) and FULL (O_valid=1). Transitions: EMPTY->FULL on a channel transfer; FULL->FULL on a drain with reload, or on a stall; FULL->EMPTY on a drain with no input valid.

Reset
REQ-026 SHALL, on a rising edge with RESET=1, set O=0, O_sel=0, O_valid=0 and P=0, overriding any transfer in that cycle.
REQ-027 SHALL hold all I_ready bits at 0 in every cycle in which RESET=1, including a reset asserted mid-stream; no input beat is consumed in that cycle.

Verification
REQ-028 Reset: N=4, W=4, all I_valid=1, RESET=1 for 2 cycles -> I_ready=0000, O_valid=0, O=0, O_sel=0.
REQ-029 Round-robin streaming: MODE 0, I0..I3 = 1,2,3,4, I_valid=1111, O_ready=1 -> on consecutive cycles O=1,2,3,4,1 and O_sel=0,1,2,3,0; I_ready one-hot 0001,0010,0100,1000.
REQ-030 Backpressure: O_valid=1 with O=3, O_ready=0 for 3 cycles -> O=3 stable, I_ready=0000; O_ready=1 -> the next granted beat appears the following cycle.
REQ-031 Pointer skip and wrap: P=2, I_valid=0001 -> grant channel 0, O_sel=0, P becomes 1.
REQ-032 Fixed priority: MODE 1, I_valid=1010, O_ready=1 for 4 cycles -> O_sel=1 every cycle; channel 3 is never granted.
REQ-033 Reset mid-operation: RESET=1 while FULL with I_valid=1111 -> the next cycle shows O_valid=0 and I_ready=0000; after release, the first grant goes to channel 0 (P=0).

Source files
------------

// File: rtl/arb_mux.sv
// N-channel arbiter feeding a single-entry registered output stage.
// MODE 0 is round-robin from pointer P; MODE 1 is fixed priority, lowest index first.
module arb_mux #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned MODE = 0,
  localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N*W-1:0]  I,
  input  logic [N-1:0]    I_valid,
  output logic [N-1:0]    I_ready,
  output logic [W-1:0]    O,
  output logic            O_valid,
  input  logic            O_ready,
  output logic [SW-1:0]   O_sel
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  o_q, o_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant;
  logic          found;
  int unsigned   idx;
  logic          can_load;
  logic          any_valid;
  logic          xfer;

  assign O_valid   = (state_q == StFull);
  assign O         = o_q;
  assign O_sel     = sel_q;
  assign can_load  = !O_valid || O_ready;
  assign any_valid = |I_valid;
  // Reset blocks the handshake so no beat is consumed in a reset cycle.
  assign xfer      = can_load && any_valid && !RESET;
  assign I_ready   = (can_load && !RESET) ? grant : '0;

  // Search starts at P in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (MODE == 0) ? ((32'(ptr_q) + i) % N) : i;
      if (!found && I_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull: begin
        if (O_ready) state_d = xfer ? StFull : StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (xfer) begin
      o_d   = I[32'(grant_idx)*W +: W];
      sel_d = grant_idx;
      if (MODE == 0) begin
        ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StEmpty;
      o_q     <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin and one fixed-priority instance.
module tb_arb_mux;

  logic        clk;
  logic        rr_rst, fp_rst;
  logic [15:0] rr_i, fp_i;
  logic [3:0]  rr_iv, fp_iv, rr_ir, fp_ir;
  logic [3:0]  rr_o, fp_o;
  logic        rr_ov, fp_ov, rr_or, fp_or;
  logic [1:0]  rr_sel, fp_sel;

  int n_vec = 0;
  int n_err = 0;

  arb_mux #(.N(4), .W(4), .MODE(0)) u_rr (
    .CLK(clk), .RESET(rr_rst), .I(rr_i), .I_valid(rr_iv), .I_ready(rr_ir),
    .O(rr_o), .O_valid(rr_ov), .O_ready(rr_or), .O_sel(rr_sel)
  );

  arb_mux #(.N(4), .W(4), .MODE(1)) u_fp (
    .CLK(clk), .RESET(fp_rst), .I(fp_i), .I_valid(fp_iv), .I_ready(fp_ir),
    .O(fp_o), .O_valid(fp_ov), .O_ready(fp_or), .O_sel(fp_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_o   [7];
    logic [1:0] exp_sel [7];
    logic [3:0] exp_rdy [7];
    exp_o   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3};
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    exp_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rr_rst = 1'b1; fp_rst = 1'b1;
    rr_i   = 16'h4321; fp_i = 16'h4321;
    rr_iv  = 4'b1111; fp_iv = 4'b1111;
    rr_or  = 1'b1; fp_or = 1'b1;

    // Reset with all inputs valid
    step();
    step();
    check("rst_ready", 32'(rr_ir), 32'h0);
    check("rst_valid", 32'(rr_ov), 32'h0);
    check("rst_o",     32'(rr_o),  32'h0);
    check("rst_sel",   32'(rr_sel), 32'h0);
    check("rst_fp_ready", 32'(fp_ir), 32'h0);

    // Round-robin streaming
    rr_rst = 1'b0;
    #1;
    check("rr_ready_first", 32'(rr_ir), 32'b0001);
    for (int k = 0; k < 7; k++) begin
      step();
      check("rr_o",     32'(rr_o),   32'(exp_o[k]));
      check("rr_sel",   32'(rr_sel), 32'(exp_sel[k]));
      check("rr_valid", 32'(rr_ov),  32'h1);
      check("rr_ready", 32'(rr_ir),  32'(exp_rdy[k]));
    end

    // Backpressure holding O=3
    rr_or = 1'b0;
    #1;
    check("bp_ready", 32'(rr_ir), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_o",       32'(rr_o),   32'd3);
      check("bp_sel",     32'(rr_sel), 32'd2);
      check("bp_valid",   32'(rr_ov),  32'h1);
      check("bp_ready_h", 32'(rr_ir),  32'h0);
    end
    rr_or = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_ir), 32'b1000);
    step();
    check("bp_next_o",   32'(rr_o),   32'd4);
    check("bp_next_sel", 32'(rr_sel), 32'd3);

    // Drain with nothing valid: O/O_sel retained
    rr_iv = 4'b0000;
    #1;
    check("drain_ready", 32'(rr_ir), 32'h0);
    step();
    check("drain_valid", 32'(rr_ov),  32'h0);
    check("drain_o",     32'(rr_o),   32'd4);
    check("drain_sel",   32'(rr_sel), 32'd3);

    // Pointer skip and wrap: P=0 -> grant 1 -> P=2 -> only ch0 valid
    rr_iv = 4'b0010;
    #1;
    check("wrap_ready1", 32'(rr_ir), 32'b0010);
    step();
    check("wrap_sel1", 32'(rr_sel), 32'd1);
    rr_iv = 4'b0001;
    #1;
    check("wrap_ready0", 32'(rr_ir), 32'b0001);
    step();
    check("wrap_o0",   32'(rr_o),   32'd1);
    check("wrap_sel0", 32'(rr_sel), 32'd0);
    // P should now be 1: with ch0 and ch2 valid, ch2 wins
    rr_iv = 4'b0101;
    #1;
    check("wrap_ptr1", 32'(rr_ir), 32'b0100);
    step();
    check("wrap_sel2", 32'(rr_sel), 32'd2);

    // Reset mid-stream while FULL (P=3 before reset)
    rr_iv = 4'b1111;
    rr_rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rr_ir), 32'h0);
    step();
    check("mid_rst_valid", 32'(rr_ov),  32'h0);
    check("mid_rst_o",     32'(rr_o),   32'h0);
    check("mid_rst_sel",   32'(rr_sel), 32'h0);
    rr_rst = 1'b0;
    #1;
    check("mid_rst_grant", 32'(rr_ir), 32'b0001);
    step();
    check("mid_rst_o1",   32'(rr_o),   32'd1);
    check("mid_rst_sel1", 32'(rr_sel), 32'd0);

    // Fixed priority: ch1 always beats ch3
    fp_iv  = 4'b1010;
    fp_rst = 1'b0;
    #1;
    check("fp_ready_first", 32'(fp_ir), 32'b0010);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fp_sel",   32'(fp_sel), 32'd1);
      check("fp_o",     32'(fp_o),   32'd2);
      check("fp_valid", 32'(fp_ov),  32'h1);
      check("fp_ready", 32'(fp_ir),  32'b0010);
    end
    fp_iv = 4'b1111;
    #1;
    check("fp_lowest", 32'(fp_ir), 32'b0001);
    step();
    check("fp_sel0", 32'(fp_sel), 32'd0);
    check("fp_o0",   32'(fp_o),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
